// File: rtl/crcu_rst_seq.sv
// crcu_rst_seq: multi-channel reset controller. Channels release in index
// order after power-on. Each channel also accepts timed software reset pulses
// and has its own enable, assertion mode, polarity and hold length.

// One reset channel: POR/WAIT_PREV -> HOLD -> RELEASE -> IDLE, and back to
// HOLD on a software request.
module crcu_rst_ch #(
   parameter int SYNC_STAGES = 2,
   parameter bit FIRST       = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] ctl,
   input  logic        sw_req,
   input  logic        prev_ok,   // predecessor released or disabled
   output logic        rst_out,
   output logic        busy,
   output logic        done,
   output logic        ok_out     // this channel counts as done for the next one
);
   localparam int SW = $clog2(SYNC_STAGES + 1);

   typedef enum logic [2:0] {S_POR, S_WAIT_PREV, S_HOLD, S_RELEASE, S_IDLE} state_t;

   state_t        state_q, state_d;
   logic [7:0]    hold_q, hold_d, hold_ld;
   logic [SW-1:0] sync_q, sync_d;
   logic          done_q, done_d;
   logic          en, async_m, pol, act, eff;
   logic          unused_ctl;

   assign en         = ctl[0];
   assign async_m    = ctl[1];
   assign pol        = ctl[2];
   assign hold_ld    = (ctl[15:8] == 8'd0) ? 8'd1 : ctl[15:8];
   assign unused_ctl = ^{ctl[31:16], ctl[7:3]};

   // State, counters and the release pulse; reset puts ch0 in POR, others waiting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FIRST ? S_POR : S_WAIT_PREV;
         hold_q  <= 8'd0;
         sync_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         sync_q  <= sync_d;
         done_q  <= done_d;
      end
   end

   // Next state; a disabled channel drops to IDLE silently from anywhere.
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      sync_d  = sync_q;
      done_d  = 1'b0;
      if (!en) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_POR: begin
               state_d = S_HOLD;
               hold_d  = hold_ld;
            end
            S_WAIT_PREV: begin
               if (prev_ok) begin
                  state_d = S_HOLD;
                  hold_d  = hold_ld;
               end
            end
            S_HOLD: begin
               if (hold_q <= 8'd1) begin
                  state_d = S_RELEASE;
                  sync_d  = SW'(SYNC_STAGES);
               end else begin
                  hold_d = hold_q - 8'd1;
               end
            end
            S_RELEASE: begin
               if (sync_q <= SW'(1)) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end else begin
                  sync_d = sync_q - SW'(1);
               end
            end
            S_IDLE: begin
               if (sw_req) begin
                  state_d = S_HOLD;
                  hold_d  = hold_ld;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Only assertion may bypass the flops (async SW path); release is always registered.
   assign act     = (state_q != S_IDLE);
   assign eff     = en & (act | (async_m & sw_req & ~act));
   assign rst_out = pol ? eff : ~eff;
   assign busy    = en & act;
   assign done    = done_q;
   assign ok_out  = done_q | (~en & prev_ok);
endmodule

module crcu_rst_seq #(
   parameter int NUM_CH      = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                   CRCU_CLK,
   input  logic                   CRCU_RST,
   input  logic [32*NUM_CH-1:0]   rst_ctl_reg,
   input  logic [NUM_CH-1:0]      sw_rst_req,
   output logic [NUM_CH-1:0]      rst_out,
   output logic [NUM_CH-1:0]      rst_busy,
   output logic [NUM_CH-1:0]      rst_done
);
   // ok_chain[i] is "everything before channel i has released"; disabled
   // channels pass it straight through, so runs of them cost no cycles.
   logic [NUM_CH:0] ok_chain;
   logic            unused_tail;

   assign ok_chain[0] = 1'b1;
   assign unused_tail = ok_chain[NUM_CH];

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      crcu_rst_ch #(
         .SYNC_STAGES (SYNC_STAGES),
         .FIRST       (g == 0)
      ) u_ch (
         .clk     (CRCU_CLK),
         .rst_n   (CRCU_RST),
         .ctl     (rst_ctl_reg[32*g +: 32]),
         .sw_req  (sw_rst_req[g]),
         .prev_ok (ok_chain[g]),
         .rst_out (rst_out[g]),
         .busy    (rst_busy[g]),
         .done    (rst_done[g]),
         .ok_out  (ok_chain[g+1])
      );
   end
endmodule

// File: tb/tb_crcu_rst_seq.sv
// Self-checking bench for crcu_rst_seq (3 channels, 2 sync stages).
module tb_crcu_rst_seq;
   localparam int N = 3;
   localparam int S = 2;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [32*N-1:0] ctl;
   logic [N-1:0]   req, rst_out, busy, done;
   int             n_vec = 0;
   int             n_err = 0;

   always #5 clk = ~clk;

   crcu_rst_seq #(.NUM_CH(N), .SYNC_STAGES(S)) dut (
      .CRCU_CLK    (clk),
      .CRCU_RST    (rst_n),
      .rst_ctl_reg (ctl),
      .sw_rst_req  (req),
      .rst_out     (rst_out),
      .rst_busy    (busy),
      .rst_done    (done)
   );

   // Control word with random junk in the ignored bits.
   function automatic logic [31:0] mk(input bit en, input bit as, input bit pol, input int hold);
      logic [31:0] w;
      w = $urandom;
      w[0] = en; w[1] = as; w[2] = pol; w[15:8] = hold[7:0];
      return w;
   endfunction

   function automatic int hmax(input int h);
      return (h == 0) ? 1 : h;
   endfunction

   function automatic logic [31:0] word(input logic [32*N-1:0] c, input int i);
      return c[32*i +: 32];
   endfunction

   task automatic test_reset();
      logic [N-1:0] eo, eb;
      logic [31:0]  w;
      rst_n = 1'b0;
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < N; i++) ctl[32*i +: 32] = mk($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 7));
         req = N'($urandom);
         #3;
         for (int i = 0; i < N; i++) begin
            w = word(ctl, i);
            eo[i] = w[0] ? w[2] : ~w[2];
            eb[i] = w[0];
         end
         n_vec++;
         if (rst_out !== eo || busy !== eb || done !== '0) begin
            n_err++;
            $display("FAIL reset out=%b/%b busy=%b/%b done=%b/000 (got/exp)", rst_out, eo, busy, eb, done);
         end
      end
      req = '0;
   endtask

   // Release edges come from arithmetic: each enabled channel starts one edge
   // after the previous enabled channel releases and lasts max(HOLD,1)+S edges.
   task automatic test_power_on(input logic [32*N-1:0] cfg);
      int rel [N];
      int last;
      logic [31:0] w;
      logic [N-1:0] eo, eb, ed;
      logic a;
      rst_n = 1'b0; ctl = cfg; req = '0;
      @(negedge clk);
      last = 0;
      for (int i = 0; i < N; i++) begin
         w = word(cfg, i);
         if (w[0]) begin
            rel[i] = ((last == 0) ? 1 : last + 1) + hmax(int'(w[15:8])) + S;
            last = rel[i];
         end else rel[i] = 0;
      end
      rst_n = 1'b1;
      for (int e = 1; e <= last + 3; e++) begin
         @(posedge clk); #1;
         for (int i = 0; i < N; i++) begin
            w = word(cfg, i);
            a = w[0] && (e < rel[i]);
            eo[i] = w[2] ? a : ~a;
            eb[i] = a;
            ed[i] = w[0] && (e == rel[i]);
         end
         n_vec++;
         if (rst_out !== eo || busy !== eb || done !== ed) begin
            n_err++;
            $display("FAIL por edge=%0d out=%b/%b busy=%b/%b done=%b/%b (got/exp)", e, rst_out, eo, busy, eb, done, ed);
         end
      end
   endtask

   // Random SW traffic and control changes against a remaining-cycles model.
   task automatic test_sw_random(input int cycles);
      int rem [N];
      logic [N-1:0] dm, eo, eb;
      logic [31:0] w;
      logic eff;
      for (int i = 0; i < N; i++) begin rem[i] = 0; dm[i] = 1'b0; end
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         for (int i = 0; i < N; i++)
            if ($urandom_range(0, 7) == 0)
               ctl[32*i +: 32] = mk($urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 5));
         for (int i = 0; i < N; i++) req[i] = ($urandom_range(0, 3) == 0);
         #1;
         for (int i = 0; i < N; i++) begin
            w = word(ctl, i);
            eff = w[0] && (rem[i] > 0 || (w[1] && req[i]));
            eo[i] = w[2] ? eff : ~eff;
            eb[i] = w[0] && rem[i] > 0;
         end
         n_vec++;
         if (rst_out !== eo || busy !== eb || done !== dm) begin
            n_err++;
            $display("FAIL swrand cyc=%0d out=%b/%b busy=%b/%b done=%b/%b (got/exp)", c, rst_out, eo, busy, eb, done, dm);
         end
         @(posedge clk);
         for (int i = 0; i < N; i++) begin
            w = word(ctl, i);
            dm[i] = 1'b0;
            if (!w[0]) rem[i] = 0;
            else if (rem[i] > 0) begin
               rem[i]--;
               if (rem[i] == 0) dm[i] = 1'b1;
            end else if (req[i]) rem[i] = hmax(int'(w[15:8])) + S;
         end
      end
      req = '0;
   endtask

   // Pulse length measured by counting active cycles on ch0.
   task automatic test_sw_pulse(input bit as, input int h, input bit extra);
      int len, done_at, exp_len;
      ctl = {mk(1'b0, 1'b0, 1'b1, 1), mk(1'b0, 1'b0, 1'b1, 1), mk(1'b1, as, 1'b1, h)};
      req = '0;
      repeat (3) @(negedge clk);
      len = 0; done_at = -1;
      exp_len = hmax(h) + S + (as ? 1 : 0);
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         req[0] = (c == 0) || (extra && c == 2);
         #1;
         if (c == 0) begin
            n_vec++;
            if (rst_out[0] !== as) begin
               n_err++;
               $display("FAIL sw_req_cycle as=%0d got %b exp %b", as, rst_out[0], as);
            end
         end
         if (rst_out[0] === 1'b1) len++;
         if (done[0] === 1'b1 && done_at < 0) done_at = c;
      end
      req = '0;
      n_vec++;
      if (len != exp_len || done_at != hmax(h) + S + 1) begin
         n_err++;
         $display("FAIL sw_pulse as=%0d h=%0d extra=%0d len=%0d exp %0d done_at=%0d exp %0d", as, h, extra, len, exp_len, done_at, hmax(h) + S + 1);
      end
   endtask

   task automatic test_en_clear();
      ctl = {mk(1'b0, 1'b0, 1'b1, 1), mk(1'b0, 1'b0, 1'b1, 1), mk(1'b1, 1'b0, 1'b1, 3)};
      req = '0;
      repeat (3) @(negedge clk);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         req[0] = (c == 0);
         if (c == 4) ctl[0] = 1'b0;   // ch0 is in RELEASE here
         if (c == 8) ctl[0] = 1'b1;   // re-enable while idle
         #1;
         if (c >= 4) begin
            n_vec++;
            if (rst_out[0] !== 1'b0 || done[0] !== 1'b0 || busy[0] !== 1'b0) begin
               n_err++;
               $display("FAIL en_clear cyc=%0d out=%b busy=%b done=%b exp 0/0/0", c, rst_out[0], busy[0], done[0]);
            end
         end
      end
      req = '0;
   endtask

   task automatic test_rst_mid();
      logic [32*N-1:0] cfg;
      cfg = {mk(1'b1, 1'b0, 1'b1, 4), mk(1'b1, 1'b0, 1'b1, 4), mk(1'b1, 1'b0, 1'b1, 4)};
      rst_n = 1'b0; ctl = cfg; req = '0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      n_vec++;
      if (rst_out !== 3'b111 || busy !== 3'b111 || done !== 3'b000) begin
         n_err++;
         $display("FAIL rst_mid out=%b busy=%b done=%b exp 111/111/000", rst_out, busy, done);
      end
      test_power_on(cfg);
   endtask

   initial begin
      rst_n = 1'b0; ctl = '0; req = '0;
      test_reset();
      test_power_on({mk(1'b1, 1'b0, 1'b1, 4), mk(1'b1, 1'b0, 1'b1, 4), mk(1'b1, 1'b0, 1'b1, 4)});
      test_power_on({mk(1'b1, 1'b0, 1'b1, 4), mk(1'b0, 1'b0, 1'b0, 4), mk(1'b1, 1'b0, 1'b1, 4)});
      for (int k = 0; k < 6; k++)
         test_power_on({mk($urandom_range(0, 3) != 0, 1'b0, $urandom_range(0, 1) == 1, $urandom_range(0, 6)),
                        mk($urandom_range(0, 3) != 0, 1'b0, $urandom_range(0, 1) == 1, $urandom_range(0, 6)),
                        mk($urandom_range(0, 3) != 0, 1'b0, $urandom_range(0, 1) == 1, $urandom_range(0, 6))});
      test_sw_random(600);
      test_sw_pulse(1'b0, 3, 1'b0);
      test_sw_pulse(1'b1, 3, 1'b0);
      test_sw_pulse(1'b0, 3, 1'b1);
      test_sw_pulse(1'b0, 0, 1'b0);
      test_en_clear();
      test_rst_mid();
      test_sw_random(300);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
